// File: rtl/snax_simbacore_job_ctrl_if.sv
// snax_simbacore_job_ctrl_if: CSR-manager and SimbaCore config/busy signals of the job controller
interface snax_simbacore_job_ctrl_if #(
  parameter int NumCfg       = 5,
  parameter int RegDataWidth = 32,
  parameter int RegROCount   = 2
);
  logic [NumCfg-1:0][RegDataWidth-1:0]     csr_reg_set_i;
  logic                                    csr_reg_set_valid_i;
  logic                                    csr_reg_set_ready_o;
  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o;
  logic [NumCfg-1:0][RegDataWidth-1:0]     core_cfg_o;
  logic                                    core_cfg_valid_o;
  logic                                    core_cfg_ready_i;
  logic                                    core_busy_i;
  modport slave (
    input  csr_reg_set_i, csr_reg_set_valid_i, core_cfg_ready_i, core_busy_i,
    output csr_reg_set_ready_o, csr_reg_ro_set_o, core_cfg_o, core_cfg_valid_o
  );
  modport master (
    output csr_reg_set_i, csr_reg_set_valid_i, core_cfg_ready_i, core_busy_i,
    input  csr_reg_set_ready_o, csr_reg_ro_set_o, core_cfg_o, core_cfg_valid_o
  );
endinterface

// File: rtl/snax_simbacore_job_ctrl.sv
// snax_simbacore_job_ctrl: one-deep job queue issuing configs to SimbaCore and reporting status/cycles
module snax_simbacore_job_ctrl #(
  parameter int NumCfg       = 5,
  parameter int RegDataWidth = 32,
  parameter int RegROCount   = 2,
  parameter int StartTimeout = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  snax_simbacore_job_ctrl_if.slave bus
);
  localparam int ToW = StartTimeout > 1 ? $clog2(StartTimeout) : 1;
  typedef enum logic [1:0] {Idle, Issue, Run, Done} state_t;
  state_t                              state;
  logic [NumCfg-1:0][RegDataWidth-1:0] pend, active;
  logic                                pend_full, busy_seen, err;
  logic [ToW-1:0]                      to_cnt;
  logic [31:0]                         cyc_cnt, last_cyc, cyc_next;
  logic [7:0]                          done_cnt;
  assign cyc_next = cyc_cnt + {31'b0, ~&cyc_cnt};
  assign bus.csr_reg_set_ready_o = ~pend_full;
  assign bus.core_cfg_o = active;
  assign bus.core_cfg_valid_o = state == Issue;
  assign bus.csr_reg_ro_set_o[0] = RegDataWidth'({done_cnt, 5'b0, err, pend_full, (state != Idle) || pend_full});
  assign bus.csr_reg_ro_set_o[1] = RegDataWidth'(last_cyc);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= Idle;
      pend      <= '0;
      active    <= '0;
      pend_full <= 1'b0;
      busy_seen <= 1'b0;
      err       <= 1'b0;
      to_cnt    <= '0;
      cyc_cnt   <= '0;
      last_cyc  <= '0;
      done_cnt  <= '0;
    end else begin
      if (bus.csr_reg_set_valid_i && !pend_full) begin
        pend      <= bus.csr_reg_set_i;
        pend_full <= 1'b1;
      end
      case (state)
        Idle: if (pend_full) begin
          active    <= pend;
          pend_full <= 1'b0;
          cyc_cnt   <= '0;
          state     <= Issue;
        end
        Issue: begin
          cyc_cnt <= cyc_next;
          if (bus.core_cfg_ready_i) begin
            busy_seen <= 1'b0;
            to_cnt    <= '0;
            state     <= Run;
          end
        end
        Run: begin
          cyc_cnt   <= cyc_next;
          busy_seen <= busy_seen | bus.core_busy_i;
          // a core that never raises busy must not hang the queue
          if (busy_seen && !bus.core_busy_i) state <= Done;
          else if (!busy_seen && to_cnt == ToW'(StartTimeout - 1)) begin
            err   <= 1'b1;
            state <= Done;
          end else if (!busy_seen) to_cnt <= to_cnt + 1'b1;
        end
        default: begin
          last_cyc <= cyc_cnt;
          done_cnt <= done_cnt + 8'd1;
          state    <= Idle;
        end
      endcase
    end
  end
endmodule
